// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that shares one uart_tx serializer between NREQ
// byte-stream requesters. A granted requester owns the UART for a whole
// message, closed by a byte flagged req_last. The arbiter drives the
// serializer's start strobe and byte directly, and paces bytes from its
// done pulse, so requesters only see a valid/ready handshake.
//
// Parameters
//   NREQ            number of requesters, 2..4
//   TIMEOUT_CYCLES  idle-grant limit in clk cycles (timeout build only), >= 2
//
// Optional feature
//   UART_ARB_TIMEOUT_EN  when defined, a grant whose owner keeps req_valid low
//                        for TIMEOUT_CYCLES cycles in SEND is revoked and
//                        timeout_stb pulses. When undefined, no counter is
//                        built and timeout_stb stays 0.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   req_valid    per-requester byte valid
//   req_last     per-requester end-of-message flag for the presented byte
//   req_data     requester i byte on bits [8i+7:8i]
//   req_ready    per-requester accept (combinational)
//   grant        one-hot UART owner, zero when free
//   tx_dv        one-cycle start pulse to uart_tx.i_TX_DV
//   tx_byte      byte to uart_tx.i_TX_Byte, held until the next accept
//   tx_active    from uart_tx.o_TX_Active
//   tx_done      from uart_tx.o_TX_Done (one-cycle pulse)
//   timeout_stb  one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              timeout_stb
);

  localparam int             RRW      = $clog2(NREQ);
  localparam logic [RRW:0]   NREQ_W   = (RRW+1)'(NREQ);
  localparam logic [RRW-1:0] LAST_IDX = RRW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_tx_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [RRW-1:0]  rr_q, rr_d;
  logic            last_q, last_d;
  logic            tx_dv_q, tx_dv_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            timeout_stb_q, timeout_stb_d;

  logic [NREQ-1:0] pick_oh;
  logic            pick_found;
  logic [RRW:0]    pick_sum;
  logic [RRW-1:0]  g_idx;
  logic [RRW-1:0]  rr_after;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            handshake;
  logic            to_hit;

  // Round-robin pick: first requesting index at or above rr, wrapping.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    pick_oh    = '0;
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int off = 0; off < NREQ; off++) begin
      pick_sum = {1'b0, rr_q} + (RRW+1)'(off);
      if (pick_sum >= NREQ_W) pick_sum = pick_sum - NREQ_W;
      if (!pick_found && req_valid[pick_sum[RRW-1:0]]) begin
        pick_oh[pick_sum[RRW-1:0]] = 1'b1;
        pick_found                 = 1'b1;
      end
    end
  end

  // Owner index and the owner's request lines, selected by the one-hot grant.
  always_comb begin
    g_idx    = '0;
    sel_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        g_idx    = RRW'(i);
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  assign sel_valid = |(req_valid & grant_q);
  assign sel_last  = |(req_last & grant_q);
  assign rr_after  = (g_idx == LAST_IDX) ? '0 : g_idx + RRW'(1);

  // The tx_active term holds off a new byte while the serializer is still
  // finishing one, including a byte left over from before a reset.
  assign req_ready = (state_q == S_SEND && !tx_active) ? grant_q : '0;
  assign handshake = (state_q == S_SEND) && !tx_active && sel_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counts stalled SEND cycles; any valid from the owner, or leaving SEND,
  // returns it to zero. Hitting the last count revokes the grant on that edge.
  always_comb begin
    to_hit   = 1'b0;
    to_cnt_d = '0;
    if (state_q == S_SEND && !sel_valid) begin
      if (to_cnt_q == TO_LAST) to_hit = 1'b1;
      else                     to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    last_d        = last_q;
    tx_dv_d       = 1'b0;
    tx_byte_d     = tx_byte_q;
    timeout_stb_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_oh;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (handshake) begin
          tx_byte_d = sel_data;
          tx_dv_d   = 1'b1;
          last_d    = sel_last;
          state_d   = S_WAIT_DONE;
        end else if (to_hit) begin
          grant_d       = '0;
          rr_d          = rr_after;
          timeout_stb_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        // tx_done only matters here; a pulse in any other state is ignored.
        if (tx_done) begin
          if (last_q) begin
            grant_d = '0;
            rr_d    = rr_after;
            state_d = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      last_q        <= 1'b0;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= 8'h00;
      timeout_stb_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      last_q        <= last_d;
      tx_dv_q       <= tx_dv_d;
      tx_byte_q     <= tx_byte_d;
      timeout_stb_q <= timeout_stb_d;
    end
  end

  assign grant       = grant_q;
  assign tx_dv       = tx_dv_q;
  assign tx_byte     = tx_byte_q;
  assign timeout_stb = timeout_stb_q;

endmodule
